target_net_sync_ctrl: RTL

Initiator that refreshes the DQN target network. Every `SYNC_PERIOD` completed training steps, or on demand, it walks every node of one layer. For each node it reads the node's weight vector and bias from the main (policy) network memory, then writes them into the target-net memory's weight-update port. One instance serves one layer and drives the write side of that layer's target-net memory.

---
 rtl/target_net_sync_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/target_net_sync_ctrl.sv
// Target-network refresh initiator: copies one layer's weights and biases from the
// policy-net memory into the target-net memory, periodically or on demand.
module target_net_sync_ctrl #(
  parameter int DATA_WIDTH         = 32,
  parameter int MEM_WIDTH          = 5,
  parameter int NODE_WIDTH_CURRENT = 32,
  parameter int NODE_WIDTH_PREV    = 32,
  parameter int SYNC_PERIOD        = 16,
  parameter int TIMEOUT            = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_train_step_done,
  input  logic                                  i_force_sync,
  output logic                                  o_src_rd_en,
  output logic [MEM_WIDTH-1:0]                  o_src_addr,
  input  logic                                  i_src_valid,
  input  logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] i_src_weight,
  input  logic [DATA_WIDTH-1:0]                 i_src_bias,
  output logic                                  o_mem_enable,
  output logic                                  o_rw_mem,
  output logic                                  o_update_weight,
  output logic [MEM_WIDTH-1:0]                  o_addr,
  output logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] o_weight,
  output logic [DATA_WIDTH-1:0]                 o_bias,
  output logic                                  o_busy,
  output logic                                  o_sync_done,
  output logic                                  o_error
);

  localparam int VEC_W  = DATA_WIDTH * NODE_WIDTH_PREV;
  localparam int STEP_W = $clog2(SYNC_PERIOD + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [MEM_WIDTH-1:0] LAST_NODE = MEM_WIDTH'(NODE_WIDTH_CURRENT - 1);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(SYNC_PERIOD - 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [STEP_W-1:0]    r_step_cnt;
  logic                 r_pending;
  logic [MEM_WIDTH-1:0] r_index;
  logic [TO_W-1:0]      r_to_cnt;

  logic                 r_src_rd_en;
  logic [MEM_WIDTH-1:0] r_src_addr;
  logic                 r_mem_enable;
  logic                 r_update_weight;
  logic [MEM_WIDTH-1:0] r_addr;
  logic [VEC_W-1:0]     r_weight;
  logic [DATA_WIDTH-1:0] r_bias;
  logic                 r_busy;
  logic                 r_sync_done;
  logic                 r_error;

  logic w_period_hit;
  logic w_trigger;
  logic w_consume;

  // A force coinciding with a period completion still queues just one sync.
  assign w_period_hit = i_train_step_done && (r_step_cnt == STEP_LAST);
  assign w_trigger    = i_force_sync || w_period_hit;
  assign w_consume    = (r_state == S_IDLE) && r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_trigger) begin
        r_step_cnt <= '0;
      end else if (i_train_step_done) begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
      r_pending <= w_trigger || (r_pending && !w_consume);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_index         <= '0;
      r_to_cnt        <= '0;
      r_src_rd_en     <= 1'b0;
      r_src_addr      <= '0;
      r_mem_enable    <= 1'b0;
      r_update_weight <= 1'b0;
      r_addr          <= '0;
      r_weight        <= '0;
      r_bias          <= '0;
      r_busy          <= 1'b0;
      r_sync_done     <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_src_rd_en     <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_update_weight <= 1'b0;
      r_sync_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state     <= S_REQ;
            r_index     <= '0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_src_rd_en <= 1'b1;
            r_src_addr  <= '0;
          end
        end
        S_REQ: begin
          r_state  <= S_WAIT;
          r_to_cnt <= '0;
        end
        S_WAIT: begin
          // Valid on the final allowed wait cycle still wins over the timeout.
          if (i_src_valid) begin
            r_weight        <= i_src_weight;
            r_bias          <= i_src_bias;
            r_state         <= S_WRITE;
            r_mem_enable    <= 1'b1;
            r_update_weight <= 1'b1;
            r_addr          <= r_index;
          end else if (r_to_cnt == TO_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_index == LAST_NODE) begin
            r_state     <= S_DONE;
            r_sync_done <= 1'b1;
          end else begin
            r_index     <= r_index + 1'b1;
            r_state     <= S_REQ;
            r_src_rd_en <= 1'b1;
            r_src_addr  <= r_index + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The target port is only ever written from here, so the direction bit is tied low.
  assign o_rw_mem        = 1'b0;
  assign o_src_rd_en     = r_src_rd_en;
  assign o_src_addr      = r_src_addr;
  assign o_mem_enable    = r_mem_enable;
  assign o_update_weight = r_update_weight;
  assign o_addr          = r_addr;
  assign o_weight        = r_weight;
  assign o_bias          = r_bias;
  assign o_busy          = r_busy;
  assign o_sync_done     = r_sync_done;
  assign o_error         = r_error;

endmodule
